br_resolve_unit: RTL

BR_RESOLVE_UNIT -- requirements
Module: br_resolve_unit

---
 rtl/br_resolve_unit_pkg.sv | 36 +++
 rtl/br_resolve_unit_if.sv | 44 ++++
 rtl/br_resolve_unit_pht.sv | 40 ++++
 rtl/br_resolve_unit.sv | 122 ++++++++++++
 4 files changed

// File: rtl/br_resolve_unit_pkg.sv
// Shared CPU package for the branch resolve unit: pipeline record layout,
// BTB flag encodings, PHT counter reset value and the saturating-counter step.
package br_resolve_unit_pkg;

    // BTB lookup result as presented at fetch
    typedef enum logic [1:0] {
        BTB_MISS   = 2'b00,
        BTB_HIT_NT = 2'b10,
        BTB_HIT_T  = 2'b11
    } btb_flag_e;

    // Counters come out of reset weakly not-taken
    localparam logic [1:0] PHT_RESET_CTR = 2'b01;

    // Per-instruction prediction record carried IF -> ID -> EX
    typedef struct packed {
        logic        valid;
        logic        hit;
        logic        pred_taken;
        logic [31:0] pred_pc;
        logic [31:0] pc;
    } br_rec_t;

    // One step of a 2-bit saturating counter
    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] res;
        res = ctr;
        if (taken) begin
            if (ctr != 2'b11) res = ctr + 2'd1;
        end else begin
            if (ctr != 2'b00) res = ctr - 2'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/br_resolve_unit_if.sv
// Bundle of fetch/BTB inputs, EX branch inputs and resolution outputs.
// Optional statistic outputs appear when BR_RESOLVE_STATS_EN is defined.
interface br_resolve_unit_if;
    logic        stall;
    logic [31:0] if_pc_in;
    logic [1:0]  btb_flag;
    logic [31:0] predicted_pc;
    logic        ex_is_br;
    logic        ex_br_en;
    logic [31:0] ex_target;

    logic        update;
    logic        update_btb;
    logic [31:0] br_out;
    logic        p_tnt;
    logic [31:0] ex_pc_out;
    logic        flush;
    logic [31:0] redirect_pc;

`ifdef BR_RESOLVE_STATS_EN
    logic [31:0] br_count;
    logic [31:0] mispredict_count;

    modport master (
        output stall, if_pc_in, btb_flag, predicted_pc, ex_is_br, ex_br_en, ex_target,
        input  update, update_btb, br_out, p_tnt, ex_pc_out, flush, redirect_pc,
        input  br_count, mispredict_count
    );
    modport slave (
        input  stall, if_pc_in, btb_flag, predicted_pc, ex_is_br, ex_br_en, ex_target,
        output update, update_btb, br_out, p_tnt, ex_pc_out, flush, redirect_pc,
        output br_count, mispredict_count
    );
`else
    modport master (
        output stall, if_pc_in, btb_flag, predicted_pc, ex_is_br, ex_br_en, ex_target,
        input  update, update_btb, br_out, p_tnt, ex_pc_out, flush, redirect_pc
    );
    modport slave (
        input  stall, if_pc_in, btb_flag, predicted_pc, ex_is_br, ex_br_en, ex_target,
        output update, update_btb, br_out, p_tnt, ex_pc_out, flush, redirect_pc
    );
`endif
endinterface

// File: rtl/br_resolve_unit_pht.sv
// Pattern history table: 2^s_index two-bit saturating counters, one write
// per cycle, asynchronous read so the resolving branch sees its counter in
// the same cycle it updates it.
module pht_table
    import br_resolve_unit_pkg::*;
#(
    parameter int s_index = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [s_index-1:0] rd_idx,
    input  logic [s_index-1:0] wr_idx,
    input  logic               we,
    input  logic               taken,
    output logic [1:0]         rd_ctr
);
    localparam int N = 1 << s_index;

    logic [1:0] ctr_vec [N];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_entry
            logic [1:0] ctr_reg;

            // Counter entry: reset weakly not-taken, step on a matching write
            always_ff @(posedge clk) begin
                if (rst) begin
                    ctr_reg <= PHT_RESET_CTR;
                end else if (we && (wr_idx == s_index'(gi))) begin
                    ctr_reg <= ctr_next(ctr_reg, taken);
                end
            end

            assign ctr_vec[gi] = ctr_reg;
        end
    endgenerate

    assign rd_ctr = ctr_vec[rd_idx];

endmodule

// File: rtl/br_resolve_unit.sv
// Branch resolve unit: carries BTB predictions alongside the pipeline,
// compares them against the EX outcome, raises flush/redirect, trains the
// PHT and requests BTB updates.
// Optional feature macro: BR_RESOLVE_STATS_EN adds br_count/mispredict_count.
module br_resolve_unit
    import br_resolve_unit_pkg::*;
#(
    parameter int s_index = 4
) (
    input  logic              clk,
    input  logic              rst,
    br_resolve_unit_if.slave  bus
);
    br_rec_t if_reg, id_reg, ex_reg;
    br_rec_t if_capture;

    logic               resolve;
    logic               br_resolved;
    logic               taken;
    logic               tk_mispredict;
    logic               nt_mispredict;
    logic               flush_c;
    logic               update_c;
    logic               update_btb_c;
    logic [31:0]        redirect_c;
    logic [31:0]        br_out_c;
    logic [31:0]        ex_pc_c;
    logic               p_tnt_c;
    logic [1:0]         rd_ctr;
    logic [1:0]         ctr_post;
    logic [s_index-1:0] ex_idx;

    // Build the fetch-stage record from the BTB lookup
    always_comb begin
        if_capture            = '0;
        if_capture.valid      = 1'b1;
        if_capture.hit        = bus.btb_flag[1];
        if_capture.pred_taken = (bus.btb_flag == BTB_HIT_T);
        if_capture.pred_pc    = bus.predicted_pc;
        if_capture.pc         = bus.if_pc_in;
    end

    // Advance records IF->ID->EX unless stalled; a flush kills the younger two
    always_ff @(posedge clk) begin
        if (rst) begin
            if_reg <= '0;
            id_reg <= '0;
            ex_reg <= '0;
        end else if (!bus.stall) begin
            if_reg <= if_capture;
            id_reg <= if_reg;
            ex_reg <= id_reg;
            if (flush_c) begin
                id_reg.valid <= 1'b0;
                ex_reg.valid <= 1'b0;
            end
        end
    end

    assign ex_idx = ex_reg.pc[s_index+1:2];

    pht_table #(.s_index(s_index)) u_pht (
        .clk    (clk),
        .rst    (rst),
        .rd_idx (ex_idx),
        .wr_idx (ex_idx),
        .we     (update_c),
        .taken  (bus.ex_br_en),
        .rd_ctr (rd_ctr)
    );

    assign ctr_post = ctr_next(rd_ctr, bus.ex_br_en);

    // Compare the EX record's prediction with the actual outcome
    always_comb begin
        resolve       = ex_reg.valid && !bus.stall;
        br_resolved   = resolve && bus.ex_is_br;
        taken         = br_resolved && bus.ex_br_en;
        tk_mispredict = taken && (!ex_reg.pred_taken || (ex_reg.pred_pc != bus.ex_target));
        nt_mispredict = resolve && ex_reg.pred_taken && (!bus.ex_is_br || !bus.ex_br_en);
        flush_c       = tk_mispredict || nt_mispredict;
        update_c      = br_resolved;
        update_btb_c  = taken && (!ex_reg.hit || (ex_reg.pred_pc != bus.ex_target));
        redirect_c    = 32'd0;
        if (tk_mispredict) begin
            redirect_c = bus.ex_target;
        end else if (nt_mispredict) begin
            redirect_c = ex_reg.pc + 32'd4;
        end
        br_out_c = resolve ? bus.ex_target : 32'd0;
        ex_pc_c  = resolve ? ex_reg.pc : 32'd0;
        p_tnt_c  = update_c ? ctr_post[1] : 1'b0;
    end

    assign bus.update      = update_c;
    assign bus.update_btb  = update_btb_c;
    assign bus.br_out      = br_out_c;
    assign bus.p_tnt       = p_tnt_c;
    assign bus.ex_pc_out   = ex_pc_c;
    assign bus.flush       = flush_c;
    assign bus.redirect_pc = redirect_c;

`ifdef BR_RESOLVE_STATS_EN
    logic [31:0] br_count_reg;
    logic [31:0] mispredict_count_reg;

    // Running totals of resolved branches and flushes, wrapping naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            br_count_reg         <= 32'd0;
            mispredict_count_reg <= 32'd0;
        end else begin
            if (update_c) br_count_reg <= br_count_reg + 32'd1;
            if (flush_c)  mispredict_count_reg <= mispredict_count_reg + 32'd1;
        end
    end

    assign bus.br_count         = br_count_reg;
    assign bus.mispredict_count = mispredict_count_reg;
`endif

endmodule
